// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Arbitration is round-robin, and only one operation is outstanding at a time.
//   clk, rst_n                         clock, async active-low reset
//   req{0,1}_valid/ready/a/b/ctrl      request channels (valid/ready handshake)
//   alu_a, alu_b, alu_ctrl             registered operands/opcode to the ALU
//   alu_result, alu_zero               ALU combinational result and zero flag
//   rsp{0,1}_valid/ready/result/zero/err  response channels (owner only)
module alu_arbiter #(
  parameter  int unsigned W      = 32,
  localparam int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [W-1:0]      rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [W-1:0]      rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [CTRL_W-1:0] OP_LAST = CTRL_W'(5);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [W-1:0]        alu_a_q, alu_a_d;
  logic [W-1:0]        alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_zero_q, rsp_zero_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic [1:0][W-1:0]   rsp_result_q, rsp_result_d;

  logic any_req_c;
  logic grant_c;
  logic rsp_ready_c;

  // Sole requester wins; on a tie the port not served last wins.
  always_comb begin
    any_req_c = req0_valid | req1_valid;
    grant_c   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready  = (state_q == S_IDLE) & any_req_c & ~grant_c;
  assign req1_ready  = (state_q == S_IDLE) & any_req_c &  grant_c;
  assign rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state: accept in IDLE, capture ALU output in EXEC, hold response in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          owner_d      = grant_c;
          last_grant_d = grant_c;
          alu_a_d      = grant_c ? req1_a    : req0_a;
          alu_b_d      = grant_c ? req1_b    : req0_b;
          alu_ctrl_d   = grant_c ? req1_ctrl : req0_ctrl;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_valid_d[owner_q]  = 1'b1;
        rsp_result_d[owner_q] = alu_result;
        rsp_zero_d[owner_q]   = alu_zero;
        rsp_err_d[owner_q]    = (alu_ctrl_q > OP_LAST);
        state_d               = S_RESP;
      end
      S_RESP: begin
        // Clearing the payload keeps an idle response channel at all-zero.
        if (rsp_ready_c) begin
          rsp_valid_d[owner_q]  = 1'b0;
          rsp_result_d[owner_q] = '0;
          rsp_zero_d[owner_q]   = 1'b0;
          rsp_err_d[owner_q]    = 1'b0;
          state_d               = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp_result_q[0];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp0_err    = rsp_err_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp_result_q[1];
  assign rsp1_zero   = rsp_zero_q[1];
  assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic.
// A behavioural ALU stands in for the external ALU; expected responses come
// from the request operands and the arbitration rules.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;
  logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [W-1:0] rsp0_result, rsp1_result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
  );

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return (a < b) ? W'(1) : '0;
      4'd5:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Expected response packed as {err, zero, result}.
  function automatic logic [W+1:0] expect_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic [W-1:0] r;
    r = alu_model(a, b, c);
    return {(c > 4'd5), (r == '0), r};
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    checks++; if ({alu_a, alu_b, alu_ctrl} !== '0) $display("FAIL reset_alu got %h/%h/%h exp 0/0/0", alu_a, alu_b, alu_ctrl); else passed++;
    checks++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== '0)
      $display("FAIL reset_rsp got v0=%b r0=%h v1=%b r1=%h exp all 0", rsp0_valid, rsp0_result, rsp1_valid, rsp1_result); else passed++;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready_idle got %b exp 00", {req0_ready, req1_ready}); else passed++;
    req0_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL reset_ready_valid got %b exp 10", {req0_ready, req1_ready}); else passed++;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'd0; req0_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); else passed++;
    tick(); req0_valid = 1'b0;
    checks++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 4'd0}) $display("FAIL single_alu got %h/%h/%h exp 5/3/0", alu_a, alu_b, alu_ctrl); else passed++;
    checks++; if (rsp0_valid !== 1'b0) $display("FAIL single_early_rsp got %b exp 0", rsp0_valid); else passed++;
    tick();
    checks++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd8, 1'b0, 1'b0})
      $display("FAIL single_rsp got %b/%h/%b/%b exp 1/00000008/0/0", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err); else passed++;
    checks++; if (rsp1_valid !== 1'b0) $display("FAIL single_rsp1_quiet got %b exp 0", rsp1_valid); else passed++;
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    checks++; if (rsp0_valid !== 1'b0) $display("FAIL single_rsp_drop got %b exp 0", rsp0_valid); else passed++;
  endtask

  task automatic test_tie();
    apply_reset();
    req0_a = 32'd7;  req0_b = 32'd7;  req0_ctrl = 4'd1; req0_valid = 1'b1;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_ctrl = 4'd3; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL tie_first_grant got %b exp 10", {req0_ready, req1_ready}); else passed++;
    tick(); req0_valid = 1'b0; #1;
    checks++; if (req1_ready !== 1'b0) $display("FAIL tie_wait_exec got %b exp 0", req1_ready); else passed++;
    tick();
    checks++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd0, 1'b1, 1'b0})
      $display("FAIL tie_rsp0 got %b/%h/%b/%b exp 1/00000000/1/0", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err); else passed++;
    rsp0_ready = 1'b1; #1;
    checks++; if (req1_ready !== 1'b0) $display("FAIL tie_wait_resp got %b exp 0", req1_ready); else passed++;
    tick(); rsp0_ready = 1'b0; #1;
    checks++; if ({req1_ready, rsp0_valid} !== 2'b10) $display("FAIL tie_second_grant got ready1=%b v0=%b exp 1/0", req1_ready, rsp0_valid); else passed++;
    tick(); req1_valid = 1'b0;
    tick();
    checks++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, rsp0_valid} !== {1'b1, 32'hFF, 1'b0, 1'b0, 1'b0})
      $display("FAIL tie_rsp1 got %b/%h/%b/%b v0=%b exp 1/000000ff/0/0 v0=0", rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, rsp0_valid); else passed++;
    rsp1_ready = 1'b1; tick(); rsp1_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int             grants[$];
    logic [W+1:0]   exp0[$], exp1[$];
    int             hs0[$], hs1[$];
    int             exp_order[6] = '{0, 1, 0, 1, 0, 1};
    int             got = 0;
    int             cyc = 0;
    bit             re0 = 1'b0, re1 = 1'b0;
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'($urandom_range(0, 5)); req0_valid = 1'b1;
    req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'($urandom_range(0, 5)); req1_valid = 1'b1;
    while (got < 6 && cyc < 100) begin
      #1;
      if (rsp0_valid) begin
        got++;
        checks++;
        if (exp0.size() == 0 || {rsp0_err, rsp0_zero, rsp0_result} !== exp0[0] || cyc != hs0[0] + 2)
          $display("FAIL rr_rsp0 got %h at cycle %0d exp %h at %0d", {rsp0_err, rsp0_zero, rsp0_result}, cyc,
                   (exp0.size() != 0) ? exp0[0] : '0, (hs0.size() != 0) ? hs0[0] + 2 : -1);
        else passed++;
        if (exp0.size() != 0) begin void'(exp0.pop_front()); void'(hs0.pop_front()); end
      end
      if (rsp1_valid) begin
        got++;
        checks++;
        if (exp1.size() == 0 || {rsp1_err, rsp1_zero, rsp1_result} !== exp1[0] || cyc != hs1[0] + 2)
          $display("FAIL rr_rsp1 got %h at cycle %0d exp %h at %0d", {rsp1_err, rsp1_zero, rsp1_result}, cyc,
                   (exp1.size() != 0) ? exp1[0] : '0, (hs1.size() != 0) ? hs1[0] + 2 : -1);
        else passed++;
        if (exp1.size() != 0) begin void'(exp1.pop_front()); void'(hs1.pop_front()); end
      end
      checks++; if (req0_ready && req1_ready) $display("FAIL rr_onehot got 11 exp at most one ready"); else passed++;
      if (req0_ready) begin grants.push_back(0); exp0.push_back(expect_rsp(req0_a, req0_b, req0_ctrl)); hs0.push_back(cyc); re0 = 1'b1; end
      if (req1_ready) begin grants.push_back(1); exp1.push_back(expect_rsp(req1_a, req1_b, req1_ctrl)); hs1.push_back(cyc); re1 = 1'b1; end
      tick(); cyc++;
      if (re0) begin req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'($urandom_range(0, 5)); re0 = 1'b0; end
      if (re1) begin req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'($urandom_range(0, 5)); re1 = 1'b0; end
    end
    checks++; if (got != 6) $display("FAIL rr_timeout got %0d responses exp 6", got); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grants.size() <= i || grants[i] != exp_order[i])
        $display("FAIL rr_order[%0d] got %0d exp %0d", i, (grants.size() > i) ? grants[i] : -1, exp_order[i]);
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    req1_a = 32'hAAAA5555; req1_b = 32'hFFFFFFFF; req1_ctrl = 4'd5; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_grant got %b exp 01", {req0_ready, req1_ready}); else passed++;
    tick(); req1_valid = 1'b0;
    req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'd0; req0_valid = 1'b1; #1;
    checks++; if (req0_ready !== 1'b0) $display("FAIL bp_exec_ready0 got %b exp 0", req0_ready); else passed++;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, req0_ready} !== {1'b1, 32'h5555AAAA, 1'b0, 1'b0, 1'b0})
        $display("FAIL bp_stall[%0d] got v1=%b r1=%h z=%b e=%b rdy0=%b exp 1/5555aaaa/0/0/0", i, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, req0_ready);
      else passed++;
      tick();
    end
    rsp1_ready = 1'b1; #1;
    checks++; if ({rsp1_valid, req0_ready} !== 2'b10) $display("FAIL bp_release got v1=%b rdy0=%b exp 1/0", rsp1_valid, req0_ready); else passed++;
    tick(); rsp1_ready = 1'b0; #1;
    checks++; if ({req0_ready, rsp1_valid} !== 2'b10) $display("FAIL bp_resume got rdy0=%b v1=%b exp 1/0", req0_ready, rsp1_valid); else passed++;
    tick(); req0_valid = 1'b0;
    tick();
    checks++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd3}) $display("FAIL bp_follow_rsp got %b/%h exp 1/00000003", rsp0_valid, rsp0_result); else passed++;
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
  endtask

  task automatic test_opcodes();
    logic [W-1:0] ta[3]   = '{32'h1234, 32'd2, 32'hFFFFFFFF};
    logic [W-1:0] tb_[3]  = '{32'h5678, 32'd3, 32'd1};
    logic [3:0]   tc[3]   = '{4'h9, 4'd4, 4'd4};
    logic [W+1:0] te[3]   = '{{1'b1, 1'b1, 32'd0}, {1'b0, 1'b0, 32'd1}, {1'b0, 1'b1, 32'd0}};
    int n;
    for (int i = 0; i < 3; i++) begin
      req0_a = ta[i]; req0_b = tb_[i]; req0_ctrl = tc[i]; req0_valid = 1'b1;
      n = 0; #1;
      while (!req0_ready && n < 10) begin tick(); #1; n++; end
      checks++; if (req0_ready !== 1'b1) $display("FAIL opc_grant[%0d] got %b exp 1", i, req0_ready); else passed++;
      tick(); req0_valid = 1'b0;
      tick();
      checks++;
      if ({rsp0_valid, rsp0_err, rsp0_zero, rsp0_result} !== {1'b1, te[i]})
        $display("FAIL opc_rsp[%0d] got v=%b e=%b z=%b r=%h exp 1/%h", i, rsp0_valid, rsp0_err, rsp0_zero, rsp0_result, te[i]);
      else passed++;
      rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    bit           pend[2] = '{1'b0, 1'b0};
    logic [W-1:0] pa[2], pb[2];
    logic [3:0]   pc[2];
    bit           er[2], rr[2];
    bit           busy = 1'b0;
    int           owner = 0, age = 0, prio = 0, done = 0;
    logic [W+1:0] exp_rsp = '0;
    apply_reset();
    pa = '{'0, '0}; pb = '{'0, '0}; pc = '{'0, '0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          pa[p]   = $urandom;
          pb[p]   = ($urandom_range(0, 7) == 0) ? pa[p] : $urandom;
          pc[p]   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
        end
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_ctrl = pc[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_ctrl = pc[1];
      rr[0] = 1'($urandom); rr[1] = 1'($urandom);
      rsp0_ready = rr[0]; rsp1_ready = rr[1];
      #1;
      er[0] = !busy && pend[0] && (!pend[1] || prio == 0);
      er[1] = !busy && pend[1] && (!pend[0] || prio == 1);
      checks++; if ({req0_ready, req1_ready} !== {er[0], er[1]})
        $display("FAIL rand_ready cyc %0d got %b%b exp %b%b", cyc, req0_ready, req1_ready, er[0], er[1]); else passed++;
      checks++; if ({rsp0_valid, rsp1_valid} !== {busy && age >= 2 && owner == 0, busy && age >= 2 && owner == 1})
        $display("FAIL rand_rsp_valid cyc %0d got %b%b busy=%b owner=%0d age=%0d", cyc, rsp0_valid, rsp1_valid, busy, owner, age); else passed++;
      if (busy && age >= 2) begin
        checks++;
        if (owner == 0 && {rsp0_err, rsp0_zero, rsp0_result} !== exp_rsp)
          $display("FAIL rand_rsp0 cyc %0d got %h exp %h", cyc, {rsp0_err, rsp0_zero, rsp0_result}, exp_rsp);
        else if (owner == 1 && {rsp1_err, rsp1_zero, rsp1_result} !== exp_rsp)
          $display("FAIL rand_rsp1 cyc %0d got %h exp %h", cyc, {rsp1_err, rsp1_zero, rsp1_result}, exp_rsp);
        else passed++;
      end
      if (er[0] || er[1]) begin
        owner   = er[1] ? 1 : 0;
        busy    = 1'b1;
        age     = 1;
        prio    = 1 - owner;
        exp_rsp = expect_rsp(pa[owner], pb[owner], pc[owner]);
        pend[owner] = 1'b0;
        done++;
      end else if (busy) begin
        if (age >= 2 && rr[owner]) busy = 1'b0;
        else age++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick(); tick(); tick();
    clear_inputs();
    checks++; if (done < 20) $display("FAIL rand_progress got %0d ops exp at least 20", done); else passed++;
  endtask

  task automatic test_reset_mid_op();
    req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 4'd0; req0_valid = 1'b1;
    #1;
    tick(); req0_valid = 1'b0;
    checks++; if (alu_a !== 32'd10) $display("FAIL rst_mid_loaded got %h exp 0000000a", alu_a); else passed++;
    rst_n = 1'b0; #1;
    checks++; if ({alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid} !== '0)
      $display("FAIL rst_mid_clear got %h/%h/%h v0=%b v1=%b exp all 0", alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid); else passed++;
    tick(); rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL rst_mid_no_rsp[%0d] got %b%b exp 00", i, rsp0_valid, rsp1_valid); else passed++;
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_mid_tie got %b exp 10", {req0_ready, req1_ready}); else passed++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_opcodes();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single EX-stage ALU between two requesters, port 0 (pipeline EX issue) and port 1 (auxiliary unit, e.g. address/debug engine). It uses a valid/ready handshake with round-robin priority. Operands are registered and driven to the external ALU, and the result is captured and returned on the winning port's response channel. Only one operation is outstanding at a time.

## Interface
Parameters:
- W, 32, operand/result width (ALU is 32-bit; keep 32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- req0_ctrl / req1_ctrl  in  4  ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT unsigned, 5 XOR)
- alu_a, alu_b  out  W  registered operands to ALU
- alu_ctrl  out  4  registered opcode to ALU
- alu_result  in  W  ALU combinational result
- alu_zero  in  1  ALU zero flag
- rsp0_valid / rsp1_valid  out  1  response available
- rsp0_ready / rsp1_ready  in  1  response consumed
- rsp0_result / rsp1_result  out  W  captured result
- rsp0_zero / rsp1_zero  out  1  captured zero flag
- rsp0_err / rsp1_err  out  1  opcode was > 4'h5

## Operation
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational: if only one valid, grant it. If both are valid, grant the port not granted last (last_grant register).
  - reqN_ready = (state==IDLE) & grant==N. It is never asserted for both ports or outside IDLE.
  - On handshake, register a/b/ctrl into alu_a/alu_b/alu_ctrl, record owner, set last_grant=owner, and go to EXEC.
- EXEC:
  - Capture alu_result, alu_zero and err=(alu_ctrl>4'h5) into the owner's response registers.
  - Assert the owner's rspN_valid and go to RESP.
- RESP:
  - Hold rspN_valid/result/zero/err stable until rspN_ready.
  - On rspN_valid & rspN_ready, deassert valid and go to IDLE.
  - A new request can be accepted the cycle after the handshake.
- alu_a/alu_b/alu_ctrl hold their last value outside IDLE-handshake updates.
- The other port's rsp signals stay 0 and are never asserted.
- Illegal opcode is passed through to the ALU unchanged: result 0, zero 1, err 1.
- Non-owner rspN_ready is ignored. Requests arriving in EXEC/RESP wait with ready=0. Requesters must hold valid and operands until ready.

## Timing
- Reset (async assert, sync release): state=IDLE, last_grant=1 (port 0 wins first tie).
  - alu_a=alu_b=0, alu_ctrl=0.
  - All rsp*_valid/result/zero/err=0.
  - req*_ready is 0 unless the corresponding valid is high in IDLE.
- Latency: request handshake at cycle T; rspN_valid rises at T+2 (registered, from the EXEC capture at the T+1 edge).
- Peak throughput: one op per 3 cycles with rsp_ready held high. Each cycle of rsp_ready low adds one cycle.
- The response handshake at cycle R allows a request handshake at R+1 at the earliest.
- Reset asserted mid-EXEC/RESP drops the in-flight op: no response is produced, and priority returns to port 0.
- Simultaneous valids at every IDLE strictly alternate grants 0,1,0,1,...
- A single persistent requester is granted every time. Priority only matters on ties.

## Test plan
- Single op: req0 ADD a=5 b=3 at T.
  - Required: req0_ready=1 at T; alu_a=5, alu_b=3, alu_ctrl=0 from T+1; rsp0_valid=1 at T+2 with result=8, zero=0, err=0.
  - rsp1_valid stays 0 throughout.
- Tie after reset: both valid, req0 SUB 7-7, req1 OR 0x0F|0xF0.
  - Required: port 0 served first with result 0, zero=1; then port 1 with result 0xFF.
  - req1_ready stays low until port 0's response handshake.
- Round robin: both ports continuously valid for 6 ops.
  - Required: grant order 0,1,0,1,0,1; each response lands on the correct port with its own result.
- Backpressure: req1 XOR 0xAAAA5555^0xFFFFFFFF with rsp1_ready low for 4 cycles.
  - Required: rsp1_result=0x5555AAAA held stable; req0 ready=0 during the stall; IDLE resumes the cycle after rsp1_ready=1.
- Illegal opcode and SLT:
  - req0 ctrl=4'h9 -> result 0, zero=1, err=1.
  - req0 SLT 2<3 -> result 1, err=0.
  - SLT 0xFFFFFFFF<1 -> result 0 (unsigned compare).
- Reset mid-op: assert rst_n low during EXEC.
  - Required: all outputs return to reset values immediately; no response after release; next tie is granted to port 0.
